note_sequencer: RTL
===================

Name: note_sequencer

Overview:
- Walks the notes of the selected song in the song ROM and presents one note at a time to the note player.
- Holds each note for its stored duration, counted in beat ticks.
- Sits between mcu (play, song, reset_player) and the note player / song ROM.
- Reports end of song back to mcu via song_done.

Parameters:
- SONG_BITS, 2, song select width; the ROM holds 2^SONG_BITS songs.
- NOTE_ADDR_BITS, 5, note index width; 32 note slots per song.
- NOTE_W, 6, note code width.
- DUR_W, 6, duration width, in beats.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high; mcu's reset_player is ORed in upstream.
- play  input  1  level from mcu; high = advance, low = pause.
- song  input  SONG_BITS  song select; must be stable except across reset.
- beat  input  1  one-cycle tick from the beat generator.
- rom_addr  output  SONG_BITS+NOTE_ADDR_BITS  combinational {song, index}.
- rom_data  input  NOTE_W+DUR_W  registered ROM output, valid 1 cycle after rom_addr; {note, duration}.
- note  output  NOTE_W  current note code (registered).
- duration  output  DUR_W  current note duration (registered).
- new_note  output  1  one-cycle pulse when note/duration update.
- song_done  output  1  one-cycle pulse at end of song.

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- Reset: state=IDLE; index=0; beat counter=0; note=0; duration=0; new_note=0; song_done=0.
  - Reset mid-note aborts immediately. No song_done is issued.
- States: IDLE, FETCH, WAIT_ROM, PLAYING, ADVANCE, DONE.
- IDLE: if play=1, go to FETCH; otherwise stay.
- FETCH: rom_addr={song,index}.
  - If play=1, go to WAIT_ROM; if play=0, stay (paused before the read).
- WAIT_ROM: sample rom_data.
  - duration field=0 is the end-of-song sentinel: go to DONE; note/duration unchanged; no new_note.
  - Otherwise: note<=rom_data note field; duration<=rom_data duration field; counter<=duration; go to PLAYING.
  - new_note=1 during the first PLAYING cycle.
- Latency: play seen high in IDLE at edge k gives new_note high in the cycle after edge k+2 (3 cycles).
- PLAYING:
  - Decrement: on play=1 and beat=1, counter decrements. This includes the new_note cycle.
  - Leaving: on play=1 and beat=1 with counter=1, go to ADVANCE.
  - Pause: play=0 freezes the counter and state; beat is ignored; note/duration are held.
- ADVANCE: if index=2^NOTE_ADDR_BITS-1, go to DONE; otherwise index<=index+1 and go to FETCH.
- DONE: song_done=1 for exactly this one cycle; index<=0; note<=0; duration<=0; go to IDLE.
  - If play is still high, the same song restarts from IDLE. mcu selects a new song via reset_player.
- Dropped beats: beats arriving in IDLE, FETCH, WAIT_ROM, ADVANCE or DONE are dropped, never queued.
- Output behaviour:
  - new_note and song_done are never high in the same cycle.
  - Outputs hold between updates.
- Widths and wrap:
  - index does not wrap silently; 31 goes to DONE.
  - counter is DUR_W bits and never underflows, because it is only decremented when nonzero.
- Timing: one note of duration D with play steady consumes exactly D beats. The gap between notes is 3 cycles (ADVANCE, FETCH, WAIT_ROM).

Test Plan:
- Basic play: reset, then song=1 and play=1. ROM[32]={note 10,dur 2}. Expect rom_addr=7'd32, new_note 3 cycles later, note=10, duration=2. After 2 beats expect rom_addr=7'd33.
- Pause: during a dur=3 note, play=0 for 5 beats -> note held, no advance. play=1 -> exactly 3 more beats then advance.
- Sentinel: ROM[2]={x,dur 0}, song 0 -> notes 0 and 1 play. Then song_done pulses for 1 cycle, note=0, no third new_note.
- Full song: 32 nonzero durations of 1 beat -> 32 new_note pulses, one song_done after index 31, then index=0 and restart.
- Reset mid-note: assert reset during note 5 -> next cycle note=0, state IDLE, no song_done. With play=1 afterward, rom_addr index restarts at 0.
- Beat edge cases: beat in FETCH/WAIT_ROM is dropped. Beat coincident with new_note is counted: dur=1 advances on that beat.

Source files
------------

// File: rtl/note_sequencer.sv
// Steps through one song in the song ROM, presenting each note for its stored number of beats.
// A zero duration marks end of song; song_done pulses once and the index returns to 0.
module note_sequencer #(
   parameter int unsigned SONG_BITS      = 2,
   parameter int unsigned NOTE_ADDR_BITS = 5,
   parameter int unsigned NOTE_W         = 6,
   parameter int unsigned DUR_W          = 6
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                play,
   input  logic [SONG_BITS-1:0]                song,
   input  logic                                beat,
   output logic [SONG_BITS+NOTE_ADDR_BITS-1:0] rom_addr,
   input  logic [NOTE_W+DUR_W-1:0]             rom_data,
   output logic [NOTE_W-1:0]                   note,
   output logic [DUR_W-1:0]                    duration,
   output logic                                new_note,
   output logic                                song_done
);

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StWaitRom,
      StPlaying,
      StAdvance,
      StDone
   } state_e;

   localparam logic [NOTE_ADDR_BITS-1:0] LastIndex = '1;

   state_e                    state_q, state_d;
   logic [NOTE_ADDR_BITS-1:0] index_q, index_d;
   logic [DUR_W-1:0]          count_q, count_d;
   logic [NOTE_W-1:0]         note_q, note_d;
   logic [DUR_W-1:0]          dur_q, dur_d;
   logic                      new_note_q, new_note_d;

   logic [NOTE_W-1:0] rom_note;
   logic [DUR_W-1:0]  rom_dur;
   logic              tick;

   assign rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
   assign rom_dur  = rom_data[DUR_W-1:0];
   // Beats only count while playing and not paused; everywhere else they are dropped.
   assign tick     = play & beat;

   always_comb begin
      state_d    = state_q;
      index_d    = index_q;
      count_d    = count_q;
      note_d     = note_q;
      dur_d      = dur_q;
      new_note_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (play) state_d = StFetch;
         end
         StFetch: begin
            if (play) state_d = StWaitRom;
         end
         StWaitRom: begin
            if (rom_dur == '0) begin
               state_d = StDone;
            end else begin
               note_d     = rom_note;
               dur_d      = rom_dur;
               count_d    = rom_dur;
               new_note_d = 1'b1;
               state_d    = StPlaying;
            end
         end
         StPlaying: begin
            // count_q is at least 1 here, so the decrement cannot underflow.
            if (tick) begin
               if (count_q == DUR_W'(1)) state_d = StAdvance;
               count_d = count_q - DUR_W'(1);
            end
         end
         StAdvance: begin
            if (index_q == LastIndex) begin
               state_d = StDone;
            end else begin
               index_d = index_q + NOTE_ADDR_BITS'(1);
               state_d = StFetch;
            end
         end
         StDone: begin
            index_d = '0;
            note_d  = '0;
            dur_d   = '0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         index_q    <= '0;
         count_q    <= '0;
         note_q     <= '0;
         dur_q      <= '0;
         new_note_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         index_q    <= index_d;
         count_q    <= count_d;
         note_q     <= note_d;
         dur_q      <= dur_d;
         new_note_q <= new_note_d;
      end
   end

   assign rom_addr  = {song, index_q};
   assign note      = note_q;
   assign duration  = dur_q;
   assign new_note  = new_note_q;
   assign song_done = (state_q == StDone);

endmodule
